// File: rtl/dense_activation_layer.sv
// Three-stage fully-connected layer with a built-in none/sigmoid/tanh activation, in signed Q(WIDTH-NFRAC).NFRAC.
// Optional macro DENSE_ROUND_EN: round-half-up instead of floor when rescaling the accumulator.

module dense_activation_neuron #(
  parameter int WIDTH      = 16,
  parameter int NFRAC      = 12,
  parameter int INPUT_SIZE = 8,
  parameter int ACT        = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [0:INPUT_SIZE-1][WIDTH-1:0]    input_data,
  input  logic [0:INPUT_SIZE-1][WIDTH-1:0]    weights,
  input  logic [WIDTH-1:0]                    bias,
  output logic [WIDTH-1:0]                    output_data
);
  localparam int PW    = 2*WIDTH;
  localparam int AW    = 2*WIDTH + $clog2(INPUT_SIZE) + 1;
  localparam int SW    = WIDTH + 4;
  localparam int RND   = (NFRAC > 0) ? (1 << (NFRAC-1)) : 0;
  localparam int C_ONE = 1 << NFRAC;
  localparam int C_5   = 5 << NFRAC;
  localparam int C_B2  = (19 << NFRAC) >> 3;
  localparam int C_K2  = (27 << NFRAC) >> 5;
  localparam int C_K1  = (5 << NFRAC) >> 3;
  localparam int C_H   = C_ONE >> 1;
  localparam logic signed [AW-1:0] A_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] A_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    prod [INPUT_SIZE];
  logic signed [WIDTH-1:0] bias_q, d, y_q, d_next, y_next;
  logic signed [AW-1:0]    acc, scaled;
  logic signed [SW-1:0]    dx, fx;

  // Piecewise-linear sigmoid; SW bits leave headroom for |2x| of the most negative input.
  function automatic logic signed [SW-1:0] sigm(input logic signed [SW-1:0] x);
    logic [SW-1:0] a, y;
    a = x[SW-1] ? -x : x;
    if (a >= SW'(C_5))       y = SW'(C_ONE);
    else if (a >= SW'(C_B2)) y = (a >> 5) + SW'(C_K2);
    else if (a >= SW'(C_ONE)) y = (a >> 3) + SW'(C_K1);
    else                     y = (a >> 2) + SW'(C_H);
    return x[SW-1] ? $signed(SW'(C_ONE) - y) : $signed(y);
  endfunction

  always_comb begin
    acc = AW'(bias_q) <<< NFRAC;
    for (int i = 0; i < INPUT_SIZE; i++) acc = acc + AW'(prod[i]);
`ifdef DENSE_ROUND_EN
    acc = acc + AW'(RND);
`endif
    scaled = acc >>> NFRAC;
    if (scaled > A_MAX)      d_next = A_MAX[WIDTH-1:0];
    else if (scaled < A_MIN) d_next = A_MIN[WIDTH-1:0];
    else                     d_next = scaled[WIDTH-1:0];
  end

  always_comb begin
    dx = SW'(d);
    if (ACT == 1)      fx = sigm(dx);
    else if (ACT == 2) fx = (sigm(dx <<< 1) <<< 1) - SW'(C_ONE);
    else               fx = dx;
    // Clamp also covers formats where 1.0 itself is not representable.
    if (fx > S_MAX)      y_next = S_MAX[WIDTH-1:0];
    else if (fx < S_MIN) y_next = S_MIN[WIDTH-1:0];
    else                 y_next = fx[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < INPUT_SIZE; i++) prod[i] <= '0;
      bias_q <= '0;
      d      <= '0;
      y_q    <= '0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++)
        prod[i] <= $signed(input_data[i]) * $signed(weights[i]);
      bias_q <= bias;
      d      <= d_next;
      y_q    <= y_next;
    end
  end

  assign output_data = y_q;
endmodule

module dense_activation_layer #(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 12,
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = 8,
  parameter int ACT         = 0
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                in_valid,
  input  logic [0:INPUT_SIZE-1][WIDTH-1:0]                    input_data,
  input  logic [0:OUTPUT_SIZE-1][0:INPUT_SIZE-1][WIDTH-1:0]   weights,
  input  logic [0:OUTPUT_SIZE-1][WIDTH-1:0]                   biases,
  output logic [0:OUTPUT_SIZE-1][WIDTH-1:0]                   output_data,
  output logic                                                out_valid
);
  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  assign out_valid = vld_pipe[STAGES];

  for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_neuron
    dense_activation_neuron #(
      .WIDTH(WIDTH), .NFRAC(NFRAC), .INPUT_SIZE(INPUT_SIZE), .ACT(ACT)
    ) u_neuron (
      .clk        (clk),
      .reset      (reset),
      .input_data (input_data),
      .weights    (weights[j]),
      .bias       (biases[j]),
      .output_data(output_data[j])
    );
  end
endmodule

// File: tb/tb_dense_activation_layer.sv
// Bench for dense_activation_layer: three instances (none/sigmoid/tanh) share one stimulus stream.
module tb_dense_activation_layer;
  localparam int W = 16, NF = 12, IS = 4, OS = 2;

  logic clk = 1'b0;
  logic reset, in_valid;
  logic [0:IS-1][W-1:0]         input_data;
  logic [0:OS-1][0:IS-1][W-1:0] weights;
  logic [0:OS-1][W-1:0]         biases;
  logic [0:OS-1][W-1:0]         out_lin, out_sig, out_tan;
  logic v_lin, v_sig, v_tan;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dense_activation_layer #(.WIDTH(W), .NFRAC(NF), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .ACT(0)) u_lin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
    .weights(weights), .biases(biases), .output_data(out_lin), .out_valid(v_lin));
  dense_activation_layer #(.WIDTH(W), .NFRAC(NF), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .ACT(1)) u_sig (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
    .weights(weights), .biases(biases), .output_data(out_sig), .out_valid(v_sig));
  dense_activation_layer #(.WIDTH(W), .NFRAC(NF), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .ACT(2)) u_tan (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
    .weights(weights), .biases(biases), .output_data(out_tan), .out_valid(v_tan));

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint ref_dense(int j);
    longint acc = 0;
    for (int i = 0; i < IS; i++)
      acc += longint'($signed(input_data[i])) * longint'($signed(weights[j][i]));
    acc += longint'($signed(biases[j])) * 4096;
`ifdef DENSE_ROUND_EN
    acc += 2048;
`endif
    acc = acc >>> 12;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  function automatic longint ref_sig(longint x);
    longint a = (x < 0) ? -x : x;
    longint y;
    if (a >= 20480)     y = 4096;
    else if (a >= 9728) y = a / 32 + 3456;
    else if (a >= 4096) y = a / 8 + 2560;
    else                y = a / 4 + 2048;
    return (x < 0) ? 4096 - y : y;
  endfunction

  function automatic longint ref_act(int act, longint d);
    if (act == 1) return ref_sig(d);
    if (act == 2) return 2 * ref_sig(2 * d) - 4096;
    return d;
  endfunction

  function automatic longint get_out(int a, int j);
    if (a == 0) return longint'($signed(out_lin[j]));
    if (a == 1) return longint'($signed(out_sig[j]));
    return longint'($signed(out_tan[j]));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_stim();
    input_data = '0; weights = '0; biases = '0;
  endtask

  // Pre-activation d[j] = dj via input0 = 1.0 and weight[j][0] = dj.
  task automatic apply_d(input int d0, input int d1);
    clear_stim();
    input_data[0] = 16'd4096;
    weights[0][0] = 16'(d0);
    weights[1][0] = 16'(d1);
  endtask

  task automatic set_linear();
    clear_stim();
    for (int i = 0; i < IS; i++) begin
      input_data[i] = 16'd4096;
      weights[0][i] = 16'd4096;
    end
    biases[1] = 16'(-2048);
  endtask

  // Drive one sample at a negedge, return at the negedge where its result is visible.
  task automatic send_one();
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({v_lin, v_sig, v_tan} !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b want 000", {v_lin, v_sig, v_tan});
    end
    checks++;
    if ({out_lin, out_sig, out_tan} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {out_lin, out_sig, out_tan});
    end
    reset = 1'b0;
    set_linear();
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (v_lin !== 1'b1) begin errors++; $display("FAIL reset_prestream_valid got %b want 1", v_lin); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({v_lin, v_sig, v_tan} !== 3'b000) begin
      errors++; $display("FAIL reset_async_valid got %b want 000", {v_lin, v_sig, v_tan});
    end
    checks++;
    if ({out_lin, out_sig, out_tan} !== '0) begin
      errors++; $display("FAIL reset_async_data got %h want 0", {out_lin, out_sig, out_tan});
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (v_lin !== 1'b0) begin errors++; $display("FAIL reset_flush cycle %0d got %b want 0", k, v_lin); end
    end
    @(negedge clk) in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk) in_valid = 1'b0;
      checks++;
      if (v_lin !== (k == 3)) begin
        errors++; $display("FAIL reset_latency cycle %0d got %b want %b", k, v_lin, k == 3);
      end
    end
    checks++;
    if ($signed(out_lin[0]) !== 16'sd16384) begin
      errors++; $display("FAIL reset_first_data got %0d want 16384", $signed(out_lin[0]));
    end
  endtask

  task automatic test_linear();
    set_linear();
    @(negedge clk) in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk) in_valid = 1'b0;
      checks++;
      if (v_lin !== (k == 3)) begin
        errors++; $display("FAIL linear_latency cycle %0d got %b want %b", k, v_lin, k == 3);
      end
      if (k == 3) begin
        checks++;
        if ($signed(out_lin[0]) !== 16'sd16384) begin
          errors++; $display("FAIL linear_out0 got %0d want 16384", $signed(out_lin[0]));
        end
        checks++;
        if ($signed(out_lin[1]) !== -16'sd2048) begin
          errors++; $display("FAIL linear_out1 got %0d want -2048", $signed(out_lin[1]));
        end
      end
    end
  endtask

  task automatic test_saturation();
    clear_stim();
    for (int i = 0; i < IS; i++) begin
      input_data[i] = 16'd4096;
      weights[0][i] = 16'd28672;
      weights[1][i] = 16'(-28672);
    end
    send_one();
    checks++;
    if ($signed(out_lin[0]) !== 16'sd32767) begin
      errors++; $display("FAIL sat_pos got %0d want 32767", $signed(out_lin[0]));
    end
    checks++;
    if ($signed(out_lin[1]) !== -16'sd32768) begin
      errors++; $display("FAIL sat_neg got %0d want -32768", $signed(out_lin[1]));
    end
  endtask

  task automatic test_sigmoid();
    int dv [4] = '{0, 16384, -16384, 32767};
    int ev [4] = '{2048, 3968, 128, 4096};
    for (int p = 0; p < 2; p++) begin
      apply_d(dv[2*p], dv[2*p+1]);
      send_one();
      for (int j = 0; j < OS; j++) begin
        checks++;
        if (get_out(1, j) !== longint'(ev[2*p+j])) begin
          errors++; $display("FAIL sigmoid d=%0d got %0d want %0d", dv[2*p+j], get_out(1, j), ev[2*p+j]);
        end
      end
    end
  endtask

  task automatic test_tanh();
    int dv [6] = '{0, 1024, -1024, 32767, -32768, 20480};
    int ev [6] = '{0, 1024, -1024, 4096, -4096, 4096};
    for (int p = 0; p < 3; p++) begin
      apply_d(dv[2*p], dv[2*p+1]);
      send_one();
      for (int j = 0; j < OS; j++) begin
        checks++;
        if (get_out(2, j) !== longint'(ev[2*p+j])) begin
          errors++; $display("FAIL tanh d=%0d got %0d want %0d", dv[2*p+j], get_out(2, j), ev[2*p+j]);
        end
      end
    end
  endtask

  task automatic test_rounding();
`ifdef DENSE_ROUND_EN
    longint e0 = 1, e1 = 0;
`else
    longint e0 = 0, e1 = -1;
`endif
    clear_stim();
    input_data[0] = 16'd1;
    weights[0][0] = 16'd2048;
    weights[1][0] = 16'(-2048);
    send_one();
    checks++;
    if (get_out(0, 0) !== e0) begin errors++; $display("FAIL round_pos got %0d want %0d", get_out(0, 0), e0); end
    checks++;
    if (get_out(0, 1) !== e1) begin errors++; $display("FAIL round_neg got %0d want %0d", get_out(0, 1), e1); end
  endtask

  // Cycle k drives sample k; its result is checked at cycle k+3.
  task automatic run_stream(input string name, input int n, input bit all_valid);
    bit     ev [64];
    longint ed [64][3][OS];
    for (int k = 0; k < n + 4; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        checks++;
        if ({v_lin, v_sig, v_tan} !== {3{ev[k-3]}}) begin
          errors++; $display("FAIL %s valid sample %0d got %b want %b", name, k-3, {v_lin, v_sig, v_tan}, ev[k-3]);
        end
        if (ev[k-3]) begin
          for (int a = 0; a < 3; a++)
            for (int j = 0; j < OS; j++) begin
              checks++;
              if (get_out(a, j) !== ed[k-3][a][j]) begin
                errors++;
                $display("FAIL %s data sample %0d act %0d neuron %0d got %0d want %0d",
                         name, k-3, a, j, get_out(a, j), ed[k-3][a][j]);
              end
            end
        end
      end
      if (k < n) begin
        for (int i = 0; i < IS; i++) begin
          input_data[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16383) - 8192);
          for (int j = 0; j < OS; j++)
            weights[j][i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
        end
        for (int j = 0; j < OS; j++) biases[j] = 16'($urandom_range(0, 16383) - 8192);
        in_valid = all_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
        ev[k] = in_valid;
        for (int a = 0; a < 3; a++)
          for (int j = 0; j < OS; j++) ed[k][a][j] = ref_act(a, ref_dense(j));
      end else begin
        in_valid = 1'b0;
        ev[k] = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 10, 1'b1);
  endtask

  task automatic test_random();
    run_stream("random", 40, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    clear_stim();
    test_reset();
    test_linear();
    test_saturation();
    test_sigmoid();
    test_tanh();
    test_rounding();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dense_activation_layer.md
Name: dense_activation_layer

Overview:
- Fixed-latency, fully parallel fully-connected layer with a selectable built-in activation (none / sigmoid / tanh).
- Signed fixed-point throughout.
- Building block for the GRU cell: reset/update gates use sigmoid, the candidate hidden state uses tanh, and plain dense layers use none.

Parameters:
- WIDTH, 16, signed data/weight/bias width.
- NFRAC, 12, fractional bits (Q(WIDTH-NFRAC).NFRAC); 1.0 = 2^NFRAC.
- INPUT_SIZE, 8, number of input features.
- OUTPUT_SIZE, 8, number of output neurons.
- ACT, 0, activation select: 0 = none, 1 = sigmoid, 2 = tanh; other values behave as 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- input_data  in  signed WIDTH x [0:INPUT_SIZE-1]  feature vector.
- weights  in  signed WIDTH x [0:OUTPUT_SIZE-1][0:INPUT_SIZE-1]  row j holds the weights of neuron j.
- biases  in  signed WIDTH x [0:OUTPUT_SIZE-1]  per-neuron bias.
- output_data  out  signed WIDTH x [0:OUTPUT_SIZE-1]  activated result.
- out_valid  out  1  output_data valid.

Behaviour:
- Interface: one clock, asynchronous active-high reset. While reset is high, all pipeline registers, output_data and out_valid are 0.
- No backpressure. A new sample is accepted every cycle in_valid=1 (throughput 1/cycle). Data is ignored when in_valid=0, but the pipeline still advances.
- Stage 1 (cycle after accept): register all products p[j][i] = input_data[i]*weights[j][i], each 2*WIDTH bits. Biases are captured in the same cycle.
- Stage 2: acc[j] = sum_i p[j][i] + (biases[j] << NFRAC).
  - The accumulator is 2*WIDTH+clog2(INPUT_SIZE)+1 bits, so there is no internal overflow.
  - Scale: acc >>> NFRAC (arithmetic shift, i.e. floor).
  - Saturate to signed WIDTH: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register the result as d[j].
- Stage 3: output_data[j] = f(d[j]) registered; out_valid is in_valid delayed by 3 cycles.
- Latency is exactly 3 clocks for every ACT value (ACT=0 still uses the stage-3 register).
- Sigmoid f, piecewise-linear with all constants in Q.NFRAC, using shifts only. With a = |x|:
  - a >= 5.0: y = 1.0
  - 2.375 <= a < 5.0: y = (a>>5) + 0.84375
  - 1.0 <= a < 2.375: y = (a>>3) + 0.625
  - a < 1.0: y = (a>>2) + 0.5
  - x < 0: result is 1.0 - y.
  - |x| for the most negative value is computed in WIDTH+1 bits.
- Tanh f: tanh(x) = 2*sigmoid(2x) - 1.
  - 2x is computed in WIDTH+1 bits, with no saturation before the sigmoid breakpoints.
  - Result range is [-1.0, 1.0].
- Activation outputs never exceed 1.0. If 1.0 is not representable (WIDTH-NFRAC < 2), the output saturates to the max positive value.
- Reset mid-stream: all in-flight samples are discarded and out_valid drops immediately (asynchronous). The first sample accepted after reset deasserts appears 3 cycles later.
- Inputs must be stable only at the clock edge where in_valid=1.

Optional Feature:
- Macro DENSE_ROUND_EN.
  - Defined: stage 2 adds 2^(NFRAC-1) to acc before the >>> NFRAC, giving round-half-up.
  - Undefined: plain floor truncation.
- Saturation and latency are identical in both modes.

Test Plan:
All scenarios use WIDTH=16, NFRAC=12, INPUT_SIZE=4, OUTPUT_SIZE=2, where 1.0 = 4096.
- Reset:
  - Assert reset asynchronously mid-stream -> output_data all 0 and out_valid=0 immediately.
  - After release, a sample -> out_valid exactly 3 cycles later.
- ACT=0 linear:
  - Inputs all 4096, row0 weights all 4096, bias0=0 -> out0=16384.
  - Row1 weights all 0, bias1=-2048 -> out1=-2048.
  - Out_valid 3 cycles after in_valid.
- Saturation, ACT=0:
  - Inputs 4096, row0 weights 28672 -> out0=32767.
  - Row1 weights -28672 -> out1=-32768.
- Sigmoid, ACT=1, using weights/bias to produce pre-activation d:
  - d=0 -> 2048.
  - d=16384 (4.0) -> 3968.
  - d=-16384 -> 128.
  - d=32767 -> 4096.
- Tanh, ACT=2:
  - d=0 -> 0.
  - d=1024 (0.25) -> 1024.
  - d=-1024 -> -1024.
  - d=32767 -> 4096.
- Rounding and streaming:
  - Input0=1, weight 2048, others 0 -> out=0 without DENSE_ROUND_EN, 1 with it.
  - 10 back-to-back in_valid samples -> 10 consecutive valid outputs in order, no bubbles.
